pwm_peripheral: RTL and testbench
=================================

Name: pwm_peripheral

Overview:
- Consumes the five control registers written over SPI (output enables, PWM enables, duty cycle) and drives the 16 chip outputs.
- Each output is one of three values: forced low, forced high, or a common PWM waveform.
- The PWM waveform comes from a prescaler plus an 8-bit period counter.
- Duty-cycle updates are glitch-free: they are applied only at period boundaries.

Parameters:
CLK_DIV, 13, clk cycles per counter step (>=1); PWM period = 256*CLK_DIV clk cycles (13 -> ~3 kHz at 10 MHz)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
en_reg_out_7_0  input  8  output enable, outputs 7..0
en_reg_out_15_8  input  8  output enable, outputs 15..8
en_reg_pwm_7_0  input  8  PWM mode select, outputs 7..0
en_reg_pwm_15_8  input  8  PWM mode select, outputs 15..8
pwm_duty_cycle  input  8  duty value, 0x00 = 0 %, 0xFF = 100 %
out  output  16  registered chip outputs
period_start  output  1  registered one-cycle pulse at each PWM period start

Behaviour:
- Inputs are synchronous to clk (produced by the SPI register block); no synchronisers.
- Reset (async assert, sync release): prescaler=0, cnt=0, duty_eff=0x00, out=16'h0000, period_start=0.
- Prescaler:
  - pre_cnt counts 0..CLK_DIV-1.
  - tick=1 when pre_cnt==CLK_DIV-1; pre_cnt then returns to 0.
  - CLK_DIV=1 means tick every cycle.
  - pre_cnt width = max(1, clog2(CLK_DIV)).
- Counter:
  - 8-bit cnt increments on tick and wraps 255->0 (no saturation).
  - wrap = tick && cnt==255.
- Effective duty (duty_eff):
  - Loaded from pwm_duty_cycle on wrap only, so the new value takes effect from cnt=0.
  - Mid-period writes to pwm_duty_cycle are ignored until the next wrap; only the last value present at wrap is used.
  - The first period after reset uses duty_eff=0, so PWM outputs are low for 256*CLK_DIV cycles.
- pwm_level (combinational):
  - duty_eff==0xFF -> 1 (special case, 100 %).
  - Otherwise -> (cnt < duty_eff).
  - duty_eff==0x00 -> always 0.
  - Duty d (d<255) gives d*CLK_DIV high cycles per period.
- Per output bit i (i=0..15), computed from the current cycle's inputs and registered into out[i]; latency 1 clk:
  - en_out[i]=0 -> 0.
  - en_out[i]=1, en_pwm[i]=0 -> 1.
  - en_out[i]=1, en_pwm[i]=1 -> pwm_level.
- Enable and PWM-select changes are not shadowed. They are visible on out the cycle after the input changes, even mid-period.
- period_start is registered from wrap. It is high exactly in the first cycle where cnt==0 is reflected on out.
- Simultaneous duty write and wrap: the value present in the wrap cycle is loaded.
- Reset mid-period: all state clears immediately. Prescaler and counter restart from 0 on release.

Optional Feature:
PWM_SHADOW_EN
- Defined: duty_eff is shadowed and updated only at wrap, as described above.
- Undefined: duty_eff is pwm_duty_cycle directly, so changes take effect the cycle after the input changes (may truncate or extend the current high phase).
  - The first period after reset uses the live value.
  - period_start is still generated.

Test Plan:
- Reset, then en_out=16'hFFFF, en_pwm=0 -> out=16'hFFFF one cycle after inputs settle; assert rst_n=0 -> out=0 asynchronously.
- CLK_DIV=4, en_out=en_pwm=16'h0001, duty=0x80; skip first period -> out[0] high 512 of every 1024 cycles; period_start pulses every 1024 cycles, coincident with the rising edge of out[0].
- CLK_DIV=4, duty=0x00 -> out[0] never high; duty=0xFF -> out[0] constant 1 across a full period with no low cycle at cnt=255.
- With PWM_SHADOW_EN defined: change duty 0x40->0xC0 at cnt=0x20 -> current period keeps 256 high cycles; next period has 768 high cycles. Without the macro: same period's high phase extends to cnt=0xC0.
- Mixed map: en_out=16'hF0F0, en_pwm=16'hFF00, duty=0x80 -> out[7:4]=1 constant, out[15:12] toggling PWM, out[11:8] and out[3:0]=0.
- CLK_DIV=1, duty=0x01 -> exactly one high cycle per 256-cycle period, aligned with period_start.

Source files
------------

// File: rtl/pwm_peripheral.sv
// PWM output stage: prescaler + 8-bit period counter driving 16 outputs (low / high / PWM).
// Define PWM_SHADOW_EN to latch the duty cycle only at period boundaries.
module pwm_peripheral #(
    parameter int CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             period_start_q, period_start_d;
    logic [15:0]      out_q, out_d;
    logic [15:0]      en_out, en_pwm;
    logic [7:0]       duty_eff;
    logic             tick;
    logic             wrap;
    logic             pwm_level;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign tick   = (pre_cnt_q == PRE_MAX);
    assign wrap   = tick && (cnt_q == 8'hFF);

`ifdef PWM_SHADOW_EN
    logic [7:0] duty_q, duty_d;

    // The new duty is sampled in the wrap cycle so it applies from cnt==0 onwards.
    always_comb begin
        duty_d = duty_q;
        if (wrap) begin
            duty_d = pwm_duty_cycle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= 8'h00;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign duty_eff = duty_q;
`else
    assign duty_eff = pwm_duty_cycle;
`endif

    always_comb begin
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
        cnt_d     = cnt_q;
        if (tick) begin
            pre_cnt_d = '0;
            cnt_d     = cnt_q + 8'd1;
        end
    end

    // 0xFF is a special case so that full duty has no low cycle at cnt==255.
    always_comb begin
        pwm_level = (cnt_q < duty_eff);
        if (duty_eff == 8'hFF) begin
            pwm_level = 1'b1;
        end
    end

    always_comb begin
        out_d = '0;
        for (int i = 0; i < 16; i++) begin
            out_d[i] = en_out[i] & (~en_pwm[i] | pwm_level);
        end
    end

    // wrap_q marks the first cycle with cnt==0; one more stage lines the pulse up with out.
    assign wrap_d         = wrap;
    assign period_start_d = wrap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q      <= '0;
            cnt_q          <= 8'h00;
            wrap_q         <= 1'b0;
            period_start_q <= 1'b0;
            out_q          <= 16'h0000;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            cnt_q          <= cnt_d;
            wrap_q         <= wrap_d;
            period_start_q <= period_start_d;
            out_q          <= out_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral: one instance with CLK_DIV=4, one with CLK_DIV=1.
// Expectations follow PWM_SHADOW_EN when the macro is defined for the build.
module tb_pwm_peripheral;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] en_out = 16'h0000;
    logic [15:0] en_pwm = 16'h0000;
    logic [7:0]  duty = 8'h00;
    logic [15:0] out4, out1;
    logic        ps4, ps1;

    int checks = 0;
    int failures = 0;

`ifdef PWM_SHADOW_EN
    localparam int FIRST_PERIOD_HIGH = 0;
    localparam int SHADOW_PERIOD_HIGH = 256;
`else
    localparam int FIRST_PERIOD_HIGH = 512;
    localparam int SHADOW_PERIOD_HIGH = 768;
`endif

    always #5 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
        .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
        .pwm_duty_cycle(duty), .out(out4), .period_start(ps4)
    );

    pwm_peripheral #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
        .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
        .pwm_duty_cycle(duty), .out(out1), .period_start(ps1)
    );

    function automatic logic get_ps(input int sel);
        return (sel == 1) ? ps1 : ps4;
    endfunction

    function automatic logic get_bit(input int sel, input int idx);
        return (sel == 1) ? out1[idx] : out4[idx];
    endfunction

    // Advance to the next negedge where period_start is high, within a cycle bound.
    task automatic wait_ps(input int sel, input int bound);
        bit found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (get_ps(sel)) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (found !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wait_period_start dut%0d: got no pulse, expected one within %0d cycles", sel, bound);
        end
    endtask

    // Samples n consecutive negedges, starting with the current one.
    task automatic measure(input int sel, input int n, input int idx,
                           output int high, output int pulses, output logic first_val);
        high = 0;
        pulses = 0;
        first_val = get_bit(sel, idx);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            high += int'(get_bit(sel, idx));
            pulses += int'(get_ps(sel));
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (out4 !== 16'h0000 || ps4 !== 1'b0 || out1 !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_state: got out4=%h ps4=%b out1=%h, expected 0000 0 0000", out4, ps4, out1);
        end
        en_out = 16'hFFFF;
        en_pwm = 16'h0000;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out4 !== 16'hFFFF || out1 !== 16'hFFFF) begin
            failures++;
            $display("[TB] FAIL forced_high: got out4=%h out1=%h, expected ffff ffff", out4, out1);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out4 !== 16'h0000 || out1 !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL async_reset: got out4=%h out1=%h, expected 0000 0000", out4, out1);
        end
        @(negedge clk);
    endtask

    task automatic test_pwm_half();
        int high, pulses, first_at;
        logic first_val, last_val;
        en_out = 16'h0001;
        en_pwm = 16'h0001;
        duty = 8'h80;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        high = 0;
        first_at = -1;
        last_val = 1'b1;
        for (int j = 1; j <= 1100; j++) begin
            @(negedge clk);
            if (ps4) begin
                first_at = j;
                break;
            end
            high += int'(out4[0]);
            last_val = out4[0];
        end
        checks++;
        if (first_at !== 1025) begin
            failures++;
            $display("[TB] FAIL first_period_start: got sample %0d, expected 1025", first_at);
        end
        checks++;
        if (high !== FIRST_PERIOD_HIGH) begin
            failures++;
            $display("[TB] FAIL first_period_high: got %0d, expected %0d", high, FIRST_PERIOD_HIGH);
        end
        checks++;
        if (last_val !== 1'b0) begin
            failures++;
            $display("[TB] FAIL low_before_start: got %b, expected 0", last_val);
        end
        measure(4, 1024, 0, high, pulses, first_val);
        checks++;
        if (high !== 512) begin
            failures++;
            $display("[TB] FAIL half_duty_high: got %0d, expected 512", high);
        end
        checks++;
        if (pulses !== 1 || first_val !== 1'b1) begin
            failures++;
            $display("[TB] FAIL half_duty_align: got pulses=%0d rise=%b, expected 1 1", pulses, first_val);
        end
        @(negedge clk);
        checks++;
        if (ps4 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL period_length: got ps=%b after 1024 cycles, expected 1", ps4);
        end
    endtask

    task automatic test_duty_extremes();
        int high, pulses;
        logic first_val;
        duty = 8'h00;
        wait_ps(4, 1100);
        wait_ps(4, 1100);
        measure(4, 1024, 0, high, pulses, first_val);
        checks++;
        if (high !== 0) begin
            failures++;
            $display("[TB] FAIL duty_zero_high: got %0d, expected 0", high);
        end
        duty = 8'hFF;
        wait_ps(4, 1100);
        wait_ps(4, 1100);
        measure(4, 1024, 0, high, pulses, first_val);
        checks++;
        if (high !== 1024) begin
            failures++;
            $display("[TB] FAIL duty_full_high: got %0d, expected 1024", high);
        end
    endtask

    task automatic test_duty_update();
        int high, pulses;
        logic first_val;
        duty = 8'h40;
        wait_ps(4, 1100);
        wait_ps(4, 1100);
        high = 0;
        for (int i = 0; i < 1024; i++) begin
            if (i > 0) @(negedge clk);
            high += int'(out4[0]);
            if (i == 127) duty = 8'hC0;
        end
        checks++;
        if (high !== SHADOW_PERIOD_HIGH) begin
            failures++;
            $display("[TB] FAIL mid_period_write: got %0d, expected %0d", high, SHADOW_PERIOD_HIGH);
        end
        @(negedge clk);
        measure(4, 1024, 0, high, pulses, first_val);
        checks++;
        if (high !== 768 || pulses !== 1) begin
            failures++;
            $display("[TB] FAIL next_period_duty: got high=%0d pulses=%0d, expected 768 1", high, pulses);
        end
    endtask

    task automatic test_mixed_map();
        en_out = 16'hF0F0;
        en_pwm = 16'hFF00;
        duty = 8'h80;
        wait_ps(4, 1100);
        wait_ps(4, 1100);
        for (int i = 0; i <= 601; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0 || i == 511) begin
                checks++;
                if (out4 !== 16'hF0F0) begin
                    failures++;
                    $display("[TB] FAIL mixed_high_phase@%0d: got %h, expected f0f0", i, out4);
                end
            end
            if (i == 512) begin
                checks++;
                if (out4 !== 16'h00F0) begin
                    failures++;
                    $display("[TB] FAIL mixed_low_phase: got %h, expected 00f0", out4);
                end
            end
            if (i == 601) begin
                checks++;
                if (out4 !== 16'hFFFF) begin
                    failures++;
                    $display("[TB] FAIL enable_unshadowed: got %h, expected ffff", out4);
                end
            end
            if (i == 600) begin
                en_out = 16'hFFFF;
                en_pwm = 16'h0000;
            end
        end
    endtask

    task automatic test_clkdiv1();
        int high, pulses;
        logic first_val;
        en_out = 16'h0001;
        en_pwm = 16'h0001;
        duty = 8'h01;
        wait_ps(1, 300);
        wait_ps(1, 300);
        measure(1, 256, 0, high, pulses, first_val);
        checks++;
        if (high !== 1 || first_val !== 1'b1 || pulses !== 1) begin
            failures++;
            $display("[TB] FAIL clkdiv1_single_high: got high=%0d at_start=%b pulses=%0d, expected 1 1 1",
                     high, first_val, pulses);
        end
        @(negedge clk);
        checks++;
        if (ps1 !== 1'b1 || out1[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL clkdiv1_period: got ps=%b out=%b, expected 1 1", ps1, out1[0]);
        end
    endtask

    initial begin
        test_reset();
        test_pwm_half();
        test_duty_extremes();
        test_duty_update();
        test_mixed_map();
        test_clkdiv1();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
